// File: rtl/acc_frame_driver.sv
// acc_frame_driver: loads a frame of signed 8-bit samples, streams it toward
// an accumulator, and checks the accumulator result against a local sum.
// The optional response timeout is enabled by defining FRAME_DRV_TIMEOUT_EN.
module acc_frame_driver #(
    parameter int FRAME_LEN = 16,
    parameter int TIMEOUT   = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wr_en,
    input  logic signed [7:0]  i_wr_data,
    output logic               o_wr_ready,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_valid,
    output logic signed [7:0]  o_x,
    input  logic               i_acc_valid,
    input  logic signed [11:0] i_acc,
    output logic signed [11:0] o_expected,
    output logic               o_done,
    output logic               o_match,
    output logic               o_timeout
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int IW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       load_cnt;
    logic [CW-1:0]       idx;
    logic signed [7:0]   buffer [FRAME_LEN];
    logic                wr_fire;
    logic                start_fire;

`ifdef FRAME_DRV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]       wait_cnt;
`endif

    assign o_wr_ready = (state == IDLE) && (load_cnt < CW'(FRAME_LEN));
    assign wr_fire    = i_wr_en && o_wr_ready;
    assign start_fire = i_start && (state == IDLE) && (load_cnt == CW'(FRAME_LEN));

    // Sample storage; contents survive reset, only the load count is cleared.
    always_ff @(posedge i_clk) begin
        if (wr_fire) buffer[load_cnt[IW-1:0]] <= i_wr_data;
    end

    // Frame FSM: load, stream, wait for the accumulator, report.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            load_cnt   <= '0;
            idx        <= '0;
            o_busy     <= 1'b0;
            o_valid    <= 1'b0;
            o_x        <= '0;
            o_expected <= '0;
            o_done     <= 1'b0;
            o_match    <= 1'b0;
            o_timeout  <= 1'b0;
`ifdef FRAME_DRV_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (wr_fire) load_cnt <= load_cnt + CW'(1);
                    if (start_fire) begin
                        // First beat is presented in the first SEND cycle.
                        state      <= SEND;
                        o_busy     <= 1'b1;
                        o_valid    <= 1'b1;
                        o_x        <= buffer[0];
                        idx        <= CW'(1);
                        o_expected <= '0;
                        o_match    <= 1'b0;
                        o_timeout  <= 1'b0;
                    end
                end
                SEND: begin
                    // Fold in the beat currently on o_x, then advance.
                    o_expected <= o_expected + {{4{o_x[7]}}, o_x};
                    if (idx == CW'(FRAME_LEN)) begin
                        state   <= WAIT;
                        o_valid <= 1'b0;
                        o_x     <= '0;
`ifdef FRAME_DRV_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else begin
                        o_x <= buffer[idx[IW-1:0]];
                        idx <= idx + CW'(1);
                    end
                end
                WAIT: begin
                    // A response in the expiry cycle still gets a normal compare.
                    if (i_acc_valid) begin
                        state     <= DONE;
                        o_match   <= (i_acc == o_expected);
                        o_timeout <= 1'b0;
                        o_done    <= 1'b1;
                        o_busy    <= 1'b0;
`ifdef FRAME_DRV_TIMEOUT_EN
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        state     <= DONE;
                        o_match   <= 1'b0;
                        o_timeout <= 1'b1;
                        o_done    <= 1'b1;
                        o_busy    <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
`endif
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    o_done   <= 1'b0;
                    load_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/acc_frame_driver.md
ACC_FRAME_DRIVER -- requirements
Module: acc_frame_driver

Interface
REQ-001 Parameter FRAME_LEN, 16, samples per frame; legal range 2..16.
REQ-002 Parameter TIMEOUT, 32, response-wait limit in cycles; used only when FRAME_DRV_TIMEOUT_EN is defined.
REQ-003 i_clk  in  1  clock; all state on rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_wr_en  in  1  load-port write strobe.
REQ-006 i_wr_data  in  8  signed sample to load.
REQ-007 o_wr_ready  out  1  high when a write will be accepted.
REQ-008 i_start  in  1  request to transmit the loaded frame.
REQ-009 o_busy  out  1  high from accepted start until o_done.
REQ-010 o_valid  out  1  sample-stream valid toward the accumulator.
REQ-011 o_x  out  8  signed sample toward the accumulator.
REQ-012 i_acc_valid  in  1  accumulator result strobe.
REQ-013 i_acc  in  12  signed accumulator result.
REQ-014 o_expected  out  12  signed sum of the transmitted frame.
REQ-015 o_done  out  1  one-cycle pulse at frame completion.
REQ-016 o_match  out  1  i_acc equalled o_expected; valid from o_done until next accepted start.
REQ-017 o_timeout  out  1  no response within TIMEOUT; same validity as o_match.

Function
REQ-018 The module SHALL implement states IDLE, SEND, WAIT, DONE.
REQ-019 IDLE: write accepted when i_wr_en and load count < FRAME_LEN; data stored at index = load count; count increments.
REQ-020 o_wr_ready SHALL equal (state==IDLE) and (load count < FRAME_LEN); writes when low SHALL be ignored.
REQ-021 i_start SHALL be accepted only in IDLE with load count == FRAME_LEN; otherwise ignored with no state change.
REQ-022 Accepted start: next cycle enter SEND; clear o_match, o_timeout, o_expected; o_busy high.
REQ-023 SEND: o_valid high for exactly FRAME_LEN consecutive cycles, o_x = buffer[0..FRAME_LEN-1] in load order, one sample per cycle, no gaps.
REQ-024 o_x SHALL be 0 whenever o_valid is low.
REQ-025 o_expected SHALL accumulate the sign-extended 12-bit sum of each sample sent, two's-complement wrap modulo 2^12 (cannot overflow for FRAME_LEN<=16).
REQ-026 After last sample, enter WAIT; o_valid low in the first WAIT cycle.
REQ-027 WAIT: on i_acc_valid, register o_match = (i_acc == o_expected), o_timeout = 0, enter DONE.
REQ-028 i_acc_valid in IDLE, SEND or DONE SHALL be ignored.
REQ-029 DONE: single cycle; o_done = 1; o_busy = 0; load count cleared to 0; return to IDLE.
REQ-030 Writes and i_start during SEND/WAIT/DONE SHALL be ignored.

Reset
REQ-031 While i_rst_n low: state IDLE, load count 0, o_valid 0, o_x 0, o_busy 0, o_done 0, o_match 0, o_timeout 0, o_expected 0, o_wr_ready 1 after release.
REQ-032 Reset assertion mid-SEND SHALL drop o_valid immediately (asynchronous) and discard the frame.
REQ-033 Buffer contents need not be cleared by reset.

Configuration
REQ-034 Macro FRAME_DRV_TIMEOUT_EN defined: WAIT counts cycles from entry; if TIMEOUT cycles elapse without i_acc_valid, set o_timeout = 1, o_match = 0, enter DONE; i_acc_valid in the same cycle as expiry wins (normal compare, o_timeout 0).
REQ-035 Macro undefined: no counter; WAIT lasts until i_acc_valid; o_timeout tied 0.

Verification
REQ-036 Load 16 x 1, start -> 16 contiguous o_valid beats of 1, o_expected = 16; i_acc=16 two cycles later -> o_done pulse, o_match=1.
REQ-037 Load -128 x 16, i_acc = -2048 -> o_expected = 0x800, o_match=1; i_acc = -2047 on rerun -> o_match=0.
REQ-038 Load 15 samples, pulse i_start -> ignored, o_busy 0, o_wr_ready 1; 16th write then start -> accepted; 17th write attempt -> ignored.
REQ-039 Assert i_rst_n low at beat 7 of SEND -> o_valid 0 same cycle; after release o_wr_ready 1, load count 0, i_acc_valid ignored.
REQ-040 With FRAME_DRV_TIMEOUT_EN, TIMEOUT=32, no response -> o_done exactly 32 cycles after WAIT entry, o_timeout=1, o_match=0; without macro, o_busy stays high until i_acc_valid.
